// File: rtl/fire6_squeeze_bias_ctrl_if.sv
// Stream bundle for the fire6 squeeze bias controller: accumulator input
// stream from the conv engine and the result stream to the squeeze buffer.
// The master modport is the environment (conv engine + output buffer), the
// slave modport is the controller.
interface fire6_squeeze_bias_ctrl_if #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned CH_W  = 6
);
    logic             acc_valid;
    logic             acc_ready;
    logic [ACC_W-1:0] acc_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CH_W-1:0]  out_ch;
    logic             out_last;

    modport master (
        output acc_valid, acc_data, out_ready,
        input  acc_ready, out_valid, out_data, out_ch, out_last
    );

    modport slave (
        input  acc_valid, acc_data, out_ready,
        output acc_ready, out_valid, out_data, out_ch, out_last
    );
endinterface

// File: rtl/fire6_squeeze_bias_ctrl.sv
// fire6 squeeze bias controller: adds the per-channel bias to each raw conv
// accumulator, rescales by an arithmetic right shift, saturates to the output
// activation width and streams the result on with valid/ready backpressure.
// Two pipeline stages (bias add, shift+saturate); a stall freezes both.
// Optional feature: define FIRE6_SQUEEZE_RELU_EN to apply ReLU before the clamp.
module fire6_squeeze_bias_ctrl #(
    parameter int unsigned NUM_CH  = 64,
    parameter int unsigned NUM_PIX = 169,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned SHIFT   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic [ACC_W-1:0]     bias_mem [NUM_CH],
    fire6_squeeze_bias_ctrl_if.slave bus
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;

    localparam logic [CH_W-1:0]  ChLast  = CH_W'(NUM_CH - 1);
    localparam logic [PIX_W-1:0] PixLast = PIX_W'(NUM_PIX - 1);

    // Clamp limits, in the stage-1 sum width so the compare is exact.
    localparam logic signed [ACC_W:0] SatMax = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic [OUT_W-1:0]      OutMax = {1'b0, {(OUT_W - 1){1'b1}}};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    // Control state
    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [PIX_W-1:0]  pix_q, pix_d;

    // Stage 1: bias-added sum
    logic                    s1_valid_q, s1_valid_d;
    logic signed [ACC_W:0]   s1_sum_q, s1_sum_d;
    logic [CH_W-1:0]         s1_ch_q, s1_ch_d;
    logic                    s1_last_q, s1_last_d;

    // Stage 2: output register
    logic                    out_valid_q, out_valid_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic [CH_W-1:0]         out_ch_q, out_ch_d;
    logic                    out_last_q, out_last_d;

    logic                    stall;
    logic                    accept;
    logic                    beat_last;
    logic                    last_hs;
    logic [ACC_W-1:0]        bias_sel;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W:0]   sh;
    logic [OUT_W-1:0]        sat;

    assign stall         = out_valid_q & ~bus.out_ready;
    assign bus.acc_ready = (state_q == StRun) & ~stall;
    assign accept        = bus.acc_valid & bus.acc_ready;
    assign beat_last     = (ch_q == ChLast) & (pix_q == PixLast);
    assign last_hs       = out_valid_q & bus.out_ready & out_last_q;

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_last  = out_last_q;

    // Run sequencing and channel/pixel counters.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ch_d    = ch_q;
        pix_d   = pix_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    busy_d  = 1'b1;
                    ch_d    = '0;
                    pix_d   = '0;
                end
            end
            StRun: begin
                if (accept) begin
                    if (ch_q == ChLast) begin
                        ch_d  = '0;
                        pix_d = pix_q + 1'b1;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                    if (beat_last) begin
                        state_d = StDrain;
                        pix_d   = '0;
                    end
                end
            end
            StDrain: begin
                // Finished once the final result has been taken downstream.
                if (!s1_valid_q && last_hs) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Stage-1 bias add at full precision so the sum can never wrap.
    always_comb begin
        bias_sel = bias_mem[ch_q];
        sum      = {bus.acc_data[ACC_W-1], bus.acc_data} + {bias_sel[ACC_W-1], bias_sel};
    end

    // Stage-2 rescale (floor shift) and clamp to the output range.
    always_comb begin
        sh = s1_sum_q >>> SHIFT;
`ifdef FIRE6_SQUEEZE_RELU_EN
        if (sh[ACC_W]) begin
            sat = '0;
        end else if (sh > SatMax) begin
            sat = OutMax;
        end else begin
            sat = sh[OUT_W-1:0];
        end
`else
        if (sh > SatMax) begin
            sat = OutMax;
        end else if (sh < ~SatMax) begin
            sat = ~OutMax;
        end else begin
            sat = sh[OUT_W-1:0];
        end
`endif
    end

    // Pipeline advance; everything holds while the output is stalled.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        s1_ch_d     = s1_ch_q;
        s1_last_d   = s1_last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_sum_d  = sum;
                s1_ch_d   = ch_q;
                s1_last_d = beat_last;
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = sat;
                out_ch_d   = s1_ch_q;
                out_last_d = s1_last_q;
            end else begin
                // Keep out_last from lingering past its handshake.
                out_last_d = 1'b0;
            end
        end
    end

    // State, counters and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ch_q        <= '0;
            pix_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_ch_q     <= '0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ch_q        <= ch_d;
            pix_q       <= pix_d;
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_ch_q     <= s1_ch_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_fire6_squeeze_bias_ctrl.sv
// Directed bench for fire6_squeeze_bias_ctrl with NUM_CH=64, NUM_PIX=2.
module tb_fire6_squeeze_bias_ctrl;

    localparam int NB = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] bias_mem [64];

    fire6_squeeze_bias_ctrl_if #(.ACC_W(32), .OUT_W(16), .CH_W(6)) bus ();

    fire6_squeeze_bias_ctrl #(
        .NUM_CH (64),
        .NUM_PIX(2),
        .ACC_W  (32),
        .OUT_W  (16),
        .SHIFT  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .bias_mem(bias_mem),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] acc_vec  [NB];
    logic [15:0] got_data [NB];
    logic [5:0]  got_ch   [NB];
    logic        got_last [NB];
    int   got_n, accept_cyc0, first_valid_cyc, last_hs_cyc;
    int   done_cnt, done_cyc, hold_viol, ready_viol, stall_hits;
    logic busy_at_done;

    // Reference: sign-extended add, floor shift by 4, clamp to 16-bit signed.
    function automatic logic [15:0] model(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        s = s >>> 4;
`ifdef FIRE6_SQUEEZE_RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    // Start a run and stream all beats; records results and handshake timing.
    task automatic run_stream(input int stall_at, input int stall_len, input int restart_at);
        int   cyc;
        int   in_idx;
        logic prev_stall;
        logic [15:0] prev_data;
        logic [5:0]  prev_ch;
        logic        prev_last;
        got_n = 0; accept_cyc0 = -1; first_valid_cyc = -1; last_hs_cyc = -1;
        done_cnt = 0; done_cyc = -1; hold_viol = 0; ready_viol = 0; stall_hits = 0;
        busy_at_done = 1'b1;
        prev_stall = 1'b0; prev_data = '0; prev_ch = '0; prev_last = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        in_idx = 0;
        while (cyc < 600) begin
            bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            bus.acc_valid = (in_idx < NB);
            bus.acc_data  = (in_idx < NB) ? acc_vec[in_idx] : 32'd0;
            start = (cyc == restart_at);
            #1;
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data ||
                               bus.out_ch !== prev_ch || bus.out_last !== prev_last))
                hold_viol++;
            if (bus.out_valid && !bus.out_ready) begin
                stall_hits++;
                if (bus.acc_ready) ready_viol++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            if (bus.acc_valid && bus.acc_ready) begin
                if (in_idx == 0) accept_cyc0 = cyc;
                in_idx++;
            end
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                if (got_n < NB) begin
                    got_data[got_n] = bus.out_data;
                    got_ch[got_n]   = bus.out_ch;
                    got_last[got_n] = bus.out_last;
                end
                got_n++;
                if (bus.out_last) last_hs_cyc = cyc;
            end
            prev_stall = bus.out_valid & ~bus.out_ready;
            prev_data  = bus.out_data;
            prev_ch    = bus.out_ch;
            prev_last  = bus.out_last;
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        bus.acc_valid = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        bus.acc_valid = 1'b1;
        bus.acc_data = 32'd5;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (bus.acc_ready !== 1'b0) begin n_errors++; $display("FAIL reset_acc_ready: got %b want 0", bus.acc_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 16'd0) begin n_errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        n_checks++; if (bus.out_ch !== 6'd0) begin n_errors++; $display("FAIL reset_out_ch: got %0d want 0", bus.out_ch); end
        n_checks++; if (bus.out_last !== 1'b0) begin n_errors++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        bus.acc_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_start_ignored: busy %b want 0", busy); end
    endtask

    task automatic test_idle_ignore();
        @(negedge clk);
        bus.acc_valid = 1'b1;
        bus.acc_data = 32'd1000;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (bus.acc_ready !== 1'b0) begin n_errors++; $display("FAIL idle_acc_ready: got %b want 0", bus.acc_ready); end
            n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL idle_out_valid: got %b want 0", bus.out_valid); end
            @(negedge clk);
        end
        bus.acc_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] want_neg;
        logic [15:0] want_min;
`ifdef FIRE6_SQUEEZE_RELU_EN
        want_neg = 16'd0;
        want_min = 16'd0;
`else
        want_neg = 16'hFFFB;
        want_min = 16'h8000;
`endif
        // start pulse at cycle 20 lands mid-run and must be ignored
        run_stream(10000, 0, 20);
        n_checks++; if (got_data[0] !== 16'd14) begin n_errors++; $display("FAIL basic_add: got %0d want 14", $signed(got_data[0])); end
        n_checks++; if (got_ch[0] !== 6'd0) begin n_errors++; $display("FAIL basic_ch0: got %0d want 0", got_ch[0]); end
        n_checks++; if (first_valid_cyc - accept_cyc0 !== 2) begin n_errors++; $display("FAIL basic_latency: got %0d want 2", first_valid_cyc - accept_cyc0); end
        n_checks++; if (got_data[3] !== want_neg) begin n_errors++; $display("FAIL basic_negative: got %0d want %0d", $signed(got_data[3]), $signed(want_neg)); end
        n_checks++; if (got_data[34] !== 16'h7FFF) begin n_errors++; $display("FAIL basic_sat_pos: got %0d want 32767", $signed(got_data[34])); end
        n_checks++; if (got_data[35] !== want_min) begin n_errors++; $display("FAIL basic_sat_neg: got %0d want %0d", $signed(got_data[35]), $signed(want_min)); end
        n_checks++; if (got_n !== NB) begin n_errors++; $display("FAIL basic_count: got %0d want %0d", got_n, NB); end
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        n_checks++; if (done_cyc !== last_hs_cyc + 1) begin n_errors++; $display("FAIL basic_done_timing: got %0d want %0d", done_cyc, last_hs_cyc + 1); end
        n_checks++; if (busy_at_done !== 1'b0) begin n_errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
        for (int i = 0; i < NB; i++) begin
            n_checks++; if (got_ch[i] !== 6'(i % 64)) begin n_errors++; $display("FAIL basic_ch[%0d]: got %0d want %0d", i, got_ch[i], i % 64); end
            n_checks++; if (got_last[i] !== (i == NB - 1)) begin n_errors++; $display("FAIL basic_last[%0d]: got %b", i, got_last[i]); end
            n_checks++; if (got_data[i] !== model(acc_vec[i], bias_mem[i % 64])) begin n_errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, got_data[i], model(acc_vec[i], bias_mem[i % 64])); end
        end
    endtask

    task automatic test_backpressure();
        run_stream(30, 5, -1);
        n_checks++; if (stall_hits !== 5) begin n_errors++; $display("FAIL bp_stall_cycles: got %0d want 5", stall_hits); end
        n_checks++; if (ready_viol !== 0) begin n_errors++; $display("FAIL bp_acc_ready_low: got %0d violations want 0", ready_viol); end
        n_checks++; if (hold_viol !== 0) begin n_errors++; $display("FAIL bp_output_hold: got %0d violations want 0", hold_viol); end
        n_checks++; if (got_n !== NB) begin n_errors++; $display("FAIL bp_count: got %0d want %0d", got_n, NB); end
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
        for (int i = 0; i < NB; i++) begin
            n_checks++; if (got_ch[i] !== 6'(i % 64)) begin n_errors++; $display("FAIL bp_ch[%0d]: got %0d want %0d", i, got_ch[i], i % 64); end
            n_checks++; if (got_data[i] !== model(acc_vec[i], bias_mem[i % 64])) begin n_errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_data[i], model(acc_vec[i], bias_mem[i % 64])); end
        end
    endtask

    task automatic test_reset_mid();
        int in_idx;
        int cyc;
        int seen_done;
        int seen_valid;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_idx = 0;
        cyc = 0;
        while (in_idx < 40 && cyc < 200) begin
            bus.out_ready = 1'b1;
            bus.acc_valid = 1'b1;
            bus.acc_data = acc_vec[in_idx];
            #1;
            if (bus.acc_valid && bus.acc_ready) in_idx++;
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (in_idx !== 40) begin n_errors++; $display("FAIL rstmid_beats: got %0d want 40", in_idx); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rstmid_done: got %b want 0", done); end
        n_checks++; if (bus.acc_ready !== 1'b0) begin n_errors++; $display("FAIL rstmid_acc_ready: got %b want 0", bus.acc_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 16'd0) begin n_errors++; $display("FAIL rstmid_out_data: got %h want 0", bus.out_data); end
        n_checks++; if (bus.out_ch !== 6'd0) begin n_errors++; $display("FAIL rstmid_out_ch: got %0d want 0", bus.out_ch); end
        n_checks++; if (bus.out_last !== 1'b0) begin n_errors++; $display("FAIL rstmid_out_last: got %b want 0", bus.out_last); end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        seen_valid = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (done) seen_done++;
            if (bus.out_valid) seen_valid++;
            @(negedge clk);
        end
        bus.acc_valid = 1'b0;
        n_checks++; if (seen_done !== 0) begin n_errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", seen_done); end
        n_checks++; if (seen_valid !== 0) begin n_errors++; $display("FAIL rstmid_flushed: got %0d valid cycles want 0", seen_valid); end
    endtask

    task automatic test_back_to_back();
        // First run right after the mid-run reset must start cleanly at ch0/pix0.
        run_stream(10000, 0, -1);
        n_checks++; if (got_n !== NB) begin n_errors++; $display("FAIL b2b_first_count: got %0d want %0d", got_n, NB); end
        n_checks++; if (got_ch[0] !== 6'd0) begin n_errors++; $display("FAIL b2b_first_ch0: got %0d want 0", got_ch[0]); end
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL b2b_first_done: got %0d want 1", done_cnt); end
        for (int i = 0; i < NB; i++) acc_vec[i] = 32'(200000 - i * 3000);
        acc_vec[70] = 32'h4000_0000;
        run_stream(10000, 0, -1);
        n_checks++; if (got_n !== NB) begin n_errors++; $display("FAIL b2b_count: got %0d want %0d", got_n, NB); end
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL b2b_done: got %0d want 1", done_cnt); end
        n_checks++; if (got_data[70] !== 16'h7FFF) begin n_errors++; $display("FAIL b2b_sat_pix1: got %0d want 32767", $signed(got_data[70])); end
        for (int i = 0; i < NB; i++) begin
            n_checks++; if (got_ch[i] !== 6'(i % 64)) begin n_errors++; $display("FAIL b2b_ch[%0d]: got %0d want %0d", i, got_ch[i], i % 64); end
            n_checks++; if (got_last[i] !== (i == NB - 1)) begin n_errors++; $display("FAIL b2b_last[%0d]: got %b", i, got_last[i]); end
            n_checks++; if (got_data[i] !== model(acc_vec[i], bias_mem[i % 64])) begin n_errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_data[i], model(acc_vec[i], bias_mem[i % 64])); end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) bias_mem[i] = 32'(i * 7 - 100);
        bias_mem[0]  = 32'(-18);
        bias_mem[3]  = 32'(-80);
        bias_mem[34] = 32'd1344;
        bias_mem[35] = 32'(-151);
        for (int i = 0; i < NB; i++) acc_vec[i] = 32'(i * 1000 - 50000);
        acc_vec[0]  = 32'd256;
        acc_vec[3]  = 32'd0;
        acc_vec[34] = 32'h7FFF_FFFF;
        acc_vec[35] = 32'h8000_0000;
        bus.acc_valid = 1'b0;
        bus.acc_data = 32'd0;
        bus.out_ready = 1'b1;

        test_reset();
        test_idle_ignore();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
